// File: rtl/uart_rx_oversample_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_e;

  // Two stop bits need a 5-bit tick counter; one stop bit fits in 4.
  function automatic int unsigned s_cnt_width(input int unsigned sb_tick);
    return (sb_tick > OVERSAMPLE) ? 5 : 4;
  endfunction

endpackage

// File: rtl/uart_rx_oversample_if.sv
// Serial-in / frame-out bundle between tick generator, receiver and RX FIFO.
interface uart_rx_oversample_if #(
  parameter int unsigned DBIT = 8
);

  logic            s_tick;
  logic            rx;
  logic [DBIT-1:0] rx_data;
  logic            rx_done_tick;
  logic            frame_err;
  logic            parity_err;

  modport master (
    output s_tick,
    output rx,
    input  rx_data,
    input  rx_done_tick,
    input  frame_err,
    input  parity_err
  );

  modport slave (
    input  s_tick,
    input  rx,
    output rx_data,
    output rx_done_tick,
    output frame_err,
    output parity_err
  );

endinterface

// File: rtl/uart_rx_oversample_sync2.sv
// Two-flop synchroniser for the asynchronous rx line; resets to the idle level (1).
module uart_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// UART receiver: 16x oversampled start detect, mid-bit sampling, LSB-first assembly.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  uart_rx_oversample_if.slave  bus
);

  localparam int unsigned SW = s_cnt_width(SB_TICK);
  localparam int unsigned NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic            rx_s;

  state_e          state_q,   state_d;
  logic [SW-1:0]   s_cnt_q,   s_cnt_d;
  logic [NW-1:0]   n_cnt_q,   n_cnt_d;
  logic [DBIT-1:0] shift_q,   shift_d;
  logic [DBIT-1:0] rx_data_q, rx_data_d;
  logic            done_q,    done_d;
  logic            ferr_q,    ferr_d;
`ifdef UART_RX_PARITY_EN
  logic            par_q,     par_d;
  logic            perr_q,    perr_d;
`endif

  uart_sync2 u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.rx),
    .q       (rx_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      s_cnt_q   <= '0;
      n_cnt_q   <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      s_cnt_q   <= s_cnt_d;
      n_cnt_q   <= n_cnt_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  // Next-state and datapath updates; counters move only on s_tick.
  always_comb begin
    state_d   = state_q;
    s_cnt_d   = s_cnt_q;
    n_cnt_d   = n_cnt_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    done_d    = 1'b0;
    ferr_d    = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = perr_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end

      START: begin
        if (bus.s_tick) begin
          if (s_cnt_q == S_MID) begin
            // A start bit that is gone by mid-bit was a glitch.
            if (!rx_s) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      DATA: begin
        if (bus.s_tick) begin
          if (s_cnt_q == S_LAST) begin
            shift_d = {rx_s, shift_q[DBIT-1:1]};
            s_cnt_d = '0;
            if (n_cnt_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (bus.s_tick) begin
          if (s_cnt_q == S_LAST) begin
            par_d   = rx_s;
            s_cnt_d = '0;
            state_d = STOP;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
`else
        state_d = IDLE;
`endif
      end

      STOP: begin
        if (bus.s_tick) begin
          if (s_cnt_q == S_STOP) begin
            rx_data_d = shift_q;
            ferr_d    = ~rx_s;
            done_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d    = ((^shift_q) ^ par_q) != PARITY_ODD;
`endif
            // A low stop bit may be a line break; wait for idle before rearming.
            state_d   = rx_s ? IDLE : BREAK;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_data      = rx_data_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;

`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  logic unused_parity_sense;
  assign unused_parity_sense = PARITY_ODD;
  assign bus.parity_err      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: table of frames plus glitch, break, back-to-back and reset cases.
module tb_uart_rx_oversample;

  localparam int unsigned TICK_DIV = 8;
  localparam int unsigned BIT_CLKS = 16 * TICK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic clk;
  logic reset_n;

  uart_rx_oversample_if #(.DBIT(8)) bus ();

  uart_rx_oversample #(
    .DBIT       (8),
    .SB_TICK    (16),
    .PARITY_ODD (1'b0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // s_tick: one clk wide every TICK_DIV clks, changed on the falling edge.
  int unsigned tdiv;
  initial begin
    tdiv       = 0;
    bus.s_tick = 1'b0;
    forever begin
      @(negedge clk);
      tdiv       = (tdiv == TICK_DIV - 1) ? 0 : tdiv + 1;
      bus.s_tick = (tdiv == 0);
    end
  end

  // Pulse monitor: counts rx_done_tick, keeps the last two words, flags bad pulse timing.
  logic       edge_tick;
  logic       prev_done;
  int         pulse_cnt;
  int         timing_bad;
  logic [7:0] cap_data;
  logic [7:0] prev_data;

  always @(posedge clk) edge_tick = bus.s_tick;

  initial begin
    pulse_cnt  = 0;
    timing_bad = 0;
    prev_done  = 1'b0;
    cap_data   = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.rx_done_tick === 1'b1) begin
        pulse_cnt = pulse_cnt + 1;
        prev_data = cap_data;
        cap_data  = bus.rx_data;
        if (!edge_tick || prev_done) timing_bad = timing_bad + 1;
      end
      prev_done = (bus.rx_done_tick === 1'b1);
    end
  end

  int n_checks;
  int n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.rx = b;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PE) send_bit((^d) ^ pflip);
    send_bit(stop);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pflip;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int p0;
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    bus.rx   = 1'b1;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0};
    vecs[5] = '{8'h81, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0};
    vecs[6] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, PE};
    vecs[7] = '{8'h07, 1'b1, 1'b0, 8'h07, 1'b0, 1'b0};

    // Reset values.
    wait_clks(5);
    check("reset_rx_data", 32'(bus.rx_data), 32'h0);
    check("reset_done", 32'(bus.rx_done_tick), 32'h0);
    check("reset_frame_err", 32'(bus.frame_err), 32'h0);
    check("reset_parity_err", 32'(bus.parity_err), 32'h0);
    reset_n = 1'b1;
    wait_clks(BIT_CLKS);

    // Short low glitch on the line must not produce a frame.
    p0 = pulse_cnt;
    bus.rx = 1'b0;
    wait_clks(3 * TICK_DIV);
    bus.rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check("glitch_no_pulse", 32'(pulse_cnt - p0), 32'd0);

    // Table of single frames.
    foreach (vecs[k]) begin
      p0 = pulse_cnt;
      send_frame(vecs[k].data, vecs[k].stop, vecs[k].pflip);
      if (!vecs[k].stop) wait_clks(2 * BIT_CLKS);
      bus.rx = 1'b1;
      wait_clks(2 * BIT_CLKS);
      check($sformatf("vec%0d_pulses", k), 32'(pulse_cnt - p0), 32'd1);
      check($sformatf("vec%0d_data", k), 32'(bus.rx_data), 32'(vecs[k].exp_data));
      check($sformatf("vec%0d_frame_err", k), 32'(bus.frame_err), 32'(vecs[k].exp_ferr));
      check($sformatf("vec%0d_parity_err", k), 32'(bus.parity_err), 32'(vecs[k].exp_perr));
    end

    // Low stop bit followed by a long break: one pulse only, then recovery.
    p0 = pulse_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_clks(20 * BIT_CLKS);
    check("break_one_pulse", 32'(pulse_cnt - p0), 32'd1);
    check("break_data", 32'(bus.rx_data), 32'h3C);
    check("break_frame_err", 32'(bus.frame_err), 32'h1);
    bus.rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check("break_release_no_pulse", 32'(pulse_cnt - p0), 32'd1);
    send_frame(8'h96, 1'b1, 1'b0);
    wait_clks(BIT_CLKS);
    check("after_break_data", 32'(bus.rx_data), 32'h96);
    check("after_break_frame_err", 32'(bus.frame_err), 32'h0);

    // Back-to-back frames with no idle gap.
    p0 = pulse_cnt;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    wait_clks(2 * BIT_CLKS);
    check("b2b_pulses", 32'(pulse_cnt - p0), 32'd2);
    check("b2b_first", 32'(prev_data), 32'h00);
    check("b2b_second", 32'(bus.rx_data), 32'hFF);
    check("b2b_frame_err", 32'(bus.frame_err), 32'h0);

    // Reset in the middle of data bit 4 discards the partial frame.
    p0 = pulse_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> i));
    bus.rx = 1'(8'h5A >> 4);
    wait_clks(BIT_CLKS / 2);
    reset_n = 1'b0;
    #1;
    check("midrst_rx_data", 32'(bus.rx_data), 32'h0);
    check("midrst_done", 32'(bus.rx_done_tick), 32'h0);
    check("midrst_frame_err", 32'(bus.frame_err), 32'h0);
    check("midrst_parity_err", 32'(bus.parity_err), 32'h0);
    bus.rx = 1'b1;
    wait_clks(10);
    reset_n = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check("midrst_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_clks(BIT_CLKS);
    check("midrst_next_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("midrst_next_data", 32'(bus.rx_data), 32'h5A);
    check("midrst_next_frame_err", 32'(bus.frame_err), 32'h0);

    // Every pulse was one clk wide and followed a sampling s_tick.
    check("pulse_timing", 32'(timing_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
